// File: rtl/adc_frame_emulator.sv
// rtl/adc_frame_emulator.sv - 4-lane serial ADC frame transmitter (drdy/dclk/dout0..3)
// Serialises eight 24-bit channel words per frame, MSB first, launched on dclk falls.
module adc_frame_emulator #(
  parameter int HALF_DIV    = 4,
  parameter int FRAME_DCLKS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic signed [23:0] ch1_i,
  input  logic signed [23:0] ch2_i,
  input  logic signed [23:0] ch3_i,
  input  logic signed [23:0] ch4_i,
  input  logic signed [23:0] ch5_i,
  input  logic signed [23:0] ch6_i,
  input  logic signed [23:0] ch7_i,
  input  logic signed [23:0] ch8_i,
  output logic               dclk_o,
  output logic               drdy_o,
  output logic [3:0]         dout_o,
  output logic               load_o,
  output logic [31:0]        frame_count_o
);

  localparam int DW = $clog2(HALF_DIV);
  localparam int BW = $clog2(FRAME_DCLKS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BIT_DLAST = BW'(47);
  localparam logic [BW-1:0] BIT_GAP0  = BW'(48);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_DCLKS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic             dclk_q, dclk_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [3:0][47:0] lane_q, lane_d;
  logic [3:0]       dout_q, dout_d;
  logic             drdy_q, drdy_d;
  logic             load_q, load_d;
  logic [31:0]      fcnt_q, fcnt_d;
  logic             fall_ev;
  logic             start_frame;

  // Fall event: this edge registers dclk 1->0; all launches happen here.
  assign fall_ev = dclk_q && (div_q == DIV_LAST);

  always_comb begin
    div_d       = div_q + DW'(1);
    dclk_d      = dclk_q;
    state_d     = state_q;
    bit_d       = bit_q;
    lane_d      = lane_q;
    dout_d      = dout_q;
    drdy_d      = drdy_q;
    load_d      = 1'b0;
    fcnt_d      = fcnt_q;
    start_frame = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      dclk_d = ~dclk_q;
    end

    if (fall_ev) begin
      case (state_q)
        IDLE: begin
          dout_d = '0;
          drdy_d = 1'b0;
          if (enable_i) start_frame = 1'b1;
        end
        SHIFT: begin
          drdy_d = 1'b0;
          if (bit_q == BIT_DLAST) begin
            dout_d  = '0;
            bit_d   = BIT_GAP0;
            state_d = GAP;
          end else begin
            bit_d = bit_q + BW'(1);
            for (int k = 0; k < 4; k++) begin
              lane_d[k] = {lane_q[k][46:0], 1'b0};
              dout_d[k] = lane_q[k][46];
            end
          end
        end
        GAP: begin
          dout_d = '0;
          drdy_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (enable_i) start_frame = 1'b1;
            else          state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Back-to-back frames reuse the IDLE start path, keeping the period exact.
    if (start_frame) begin
      lane_d[0] = {ch1_i, ch2_i};
      lane_d[1] = {ch3_i, ch4_i};
      lane_d[2] = {ch5_i, ch6_i};
      lane_d[3] = {ch7_i, ch8_i};
      for (int k = 0; k < 4; k++) dout_d[k] = lane_d[k][47];
      drdy_d  = 1'b1;
      load_d  = 1'b1;
      fcnt_d  = fcnt_q + 32'd1;
      bit_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      dclk_q  <= 1'b0;
      bit_q   <= '0;
      lane_q  <= '0;
      dout_q  <= '0;
      drdy_q  <= 1'b0;
      load_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dclk_q  <= dclk_d;
      bit_q   <= bit_d;
      lane_q  <= lane_d;
      dout_q  <= dout_d;
      drdy_q  <= drdy_d;
      load_q  <= load_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign dclk_o        = dclk_q;
  assign drdy_o        = drdy_q;
  assign dout_o        = dout_q;
  assign load_o        = load_q;
  assign frame_count_o = fcnt_q;

endmodule
